// File: rtl/dice_pkg.sv
// Shared types and default timing constants for the dice button conditioner.
// The BTN_REPEAT_EN build macro enables auto-repeat in dice_btn_ch.
package dice_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} btn_state_t;

  localparam int DB_CYCLES_DEF  = 500000;
  localparam int REPEAT_DLY_DEF = 25000000;
  localparam int REPEAT_PER_DEF = 10000000;

endpackage

// File: rtl/dice_btn_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM, press pulse and level.
// BTN_REPEAT_EN adds an auto-repeat counter that runs while the button is held.
module dice_btn_ch
  import dice_pkg::*;
#(
  parameter int DB_CYCLES  = DB_CYCLES_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       btn_in,
  output logic       pulse,
  output logic       level,
  output btn_state_t state
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_TERM = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_cfg_chk
    $error("dice_btn_ch: DB_CYCLES must be >= 2 and repeat timings >= 1");
  end

  logic          sync_1;
  logic          sync_q;
  logic [CW-1:0] cnt;

`ifdef BTN_REPEAT_EN
  localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_TERM = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] PER_TERM = RW'(REPEAT_PER - 1);

  logic [RW-1:0] rpt_cnt;
  logic          rpt_first;
`endif

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_q <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
      pulse  <= 1'b0;
      level  <= 1'b0;
`ifdef BTN_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      sync_1 <= btn_in;
      sync_q <= sync_1;
      pulse  <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_q) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!sync_q) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_TERM) begin
            state <= HELD;
            level <= 1'b1;
            pulse <= 1'b1;
            cnt   <= '0;
`ifdef BTN_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!sync_q) begin
            state <= REL_CHK;
            cnt   <= '0;
`ifdef BTN_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
          end else if (rpt_cnt == (rpt_first ? DLY_TERM : PER_TERM)) begin
            // First repeat waits REPEAT_DLY, later ones REPEAT_PER.
            pulse     <= 1'b1;
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
`endif
          end
        end
        REL_CHK: begin
          if (sync_q) begin
            state <= HELD;
            cnt   <= '0;
`ifdef BTN_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end else if (cnt == CNT_TERM) begin
            state <= IDLE;
            level <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/dice_btn_cond.sv
// Button conditioner feeding the dice game ER/EL roll enables: polarity fix plus
// one debounced channel per button. BTN_REPEAT_EN enables auto-repeat pulses.
module dice_btn_cond
  import dice_pkg::*;
#(
  parameter int N_BTN          = 2,
  parameter int DB_CYCLES      = DB_CYCLES_DEF,
  parameter int BTN_ACTIVE_LOW = 0,
  parameter int REPEAT_DLY     = REPEAT_DLY_DEF,
  parameter int REPEAT_PER     = REPEAT_PER_DEF
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_pulse,
  output logic [N_BTN-1:0]   btn_level,
  output logic [2*N_BTN-1:0] dbg_state
);

  logic [N_BTN-1:0] btn_act;

  assign btn_act = (BTN_ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_state_t ch_state;

    dice_btn_ch #(
      .DB_CYCLES (DB_CYCLES),
      .REPEAT_DLY(REPEAT_DLY),
      .REPEAT_PER(REPEAT_PER)
    ) u_ch (
      .sys_clk(sys_clk),
      .reset  (reset),
      .btn_in (btn_act[i]),
      .pulse  (btn_pulse[i]),
      .level  (btn_level[i]),
      .state  (ch_state)
    );

    assign dbg_state[2*i +: 2] = ch_state;
  end

endmodule

// File: tb/tb_dice_btn_cond.sv
// Self-checking bench for dice_btn_cond: vector table, hand sequences and a
// randomized run against a run-length reference model.
module tb_dice_btn_cond;

  localparam int DB  = 4;
  localparam int DLY = 10;
  localparam int PER = 5;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [1:0] btn_raw;
  logic [1:0] btn_pulse;
  logic [1:0] btn_level;
  logic [3:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  dice_btn_cond #(
    .N_BTN         (2),
    .DB_CYCLES     (DB),
    .BTN_ACTIVE_LOW(0),
    .REPEAT_DLY    (DLY),
    .REPEAT_PER    (PER)
  ) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // reference model: level flips once the synchronised input has disagreed
  // with it for DB+1 consecutive samples; repeat age counts stable held cycles
  logic [1:0] m_d1, m_d2, m_lvl, m_pulse;
  int         m_run [2];
  int         m_age [2];
  bit         model_on = 1'b0;
  logic [3:0] exp_q[$];

  always @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pulse = '0;
      for (int c = 0; c < 2; c++) begin
        m_run[c] = 0;
        m_age[c] = 0;
      end
      exp_q.delete();
    end else begin
      m_pulse = '0;
      for (int c = 0; c < 2; c++) begin
        logic s;
        int   prev_run;
        s        = m_d2[c];
        m_d2[c]  = m_d1[c];
        m_d1[c]  = btn_raw[c];
        prev_run = m_run[c];
        if (s != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 1) begin
            m_lvl[c] = s;
            m_run[c] = 0;
            if (s) begin
              m_pulse[c] = 1'b1;
              m_age[c]   = 0;
            end
          end
        end else begin
          m_run[c] = 0;
          if (m_lvl[c]) begin
            if (prev_run > 0) m_age[c] = 0;
            else              m_age[c]++;
            if (REP_EN && m_age[c] >= DLY && ((m_age[c] - DLY) % PER) == 0)
              m_pulse[c] = 1'b1;
          end
        end
      end
      if (model_on) exp_q.push_back({m_pulse, m_lvl});
    end
  end

  // driver tasks
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // called at a negedge; returns at the negedge after the next active edge
  task automatic cyc(input logic [1:0] raw);
    btn_raw = raw;
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'b00);
  endtask

  typedef struct {
    logic [1:0] raw;
    logic [1:0] pulse;
    logic [1:0] level;
  } vec_t;

  vec_t tbl[20];

  initial begin
    for (int i = 0; i < 20; i++) begin
      tbl[i].raw   = (i < 10) ? 2'b01 : 2'b00;
      tbl[i].pulse = (i == 6) ? 2'b01 : 2'b00;
      tbl[i].level = (i >= 6 && i < 16) ? 2'b01 : 2'b00;
    end

    reset   = 1'b1;
    btn_raw = 2'b00;
    @(negedge sys_clk);

    // 1: outputs quiet while reset is held and pins toggle
    for (int i = 0; i < 8; i++) begin
      cyc(2'($urandom_range(0, 3)));
      check("rst_out", {btn_pulse, btn_level}, 4'h0);
      check("rst_state", dbg_state, 4'h0);
    end
    reset = 1'b0;

    // 2: single press and release on channel 0 from the vector table
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].raw);
      check($sformatf("tbl_pulse[%0d]", i), {2'b00, btn_pulse}, {2'b00, tbl[i].pulse});
      check($sformatf("tbl_level[%0d]", i), {2'b00, btn_level}, {2'b00, tbl[i].level});
    end
    idle(4);

    // 3: 3-cycle glitch on channel 1 is rejected
    for (int i = 0; i < 11; i++) begin
      cyc((i < 3) ? 2'b10 : 2'b00);
      check("glitch", {btn_pulse, btn_level}, 4'h0);
    end

    // 4: 2-cycle release glitch while held keeps level and gives no new pulse
    for (int i = 0; i < 20; i++) begin
      cyc((i == 8 || i == 9) ? 2'b00 : 2'b01);
      check("rel_glitch", {btn_pulse, btn_level},
            {(i == 6) ? 2'b01 : 2'b00, (i >= 6) ? 2'b01 : 2'b00});
    end
    idle(12);
    check("rel_done", {btn_pulse, btn_level}, 4'h0);

    // 5: simultaneous press pulses both channels in the same cycle
    for (int i = 0; i < 10; i++) begin
      cyc(2'b11);
      check("both", {btn_pulse, btn_level},
            {(i == 6) ? 2'b11 : 2'b00, (i >= 6) ? 2'b11 : 2'b00});
    end
    idle(12);

    // 6: long hold, auto-repeat only in the repeat build
    for (int i = 0; i < 37; i++) begin
      logic exp_p;
      int   k;
      cyc(2'b01);
      k     = i - 6;
      exp_p = (i == 6) ||
              (REP_EN && (k == 10 || k == 15 || k == 20 || k == 25 || k == 30));
      check($sformatf("hold[%0d]", i), {3'b000, btn_pulse[0]}, {3'b000, exp_p});
    end
    idle(12);

    // 7: reset mid-check, button still held at release gives a fresh debounce
    for (int i = 0; i < 4; i++) cyc(2'b10);
    reset = 1'b1;
    #1;
    check("mid_rst_out", {btn_pulse, btn_level}, 4'h0);
    check("mid_rst_state", dbg_state, 4'h0);
    @(negedge sys_clk);
    cyc(2'b10);
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      cyc(2'b10);
      check("post_rst", {btn_pulse, btn_level},
            {(i == 6) ? 2'b10 : 2'b00, (i >= 6) ? 2'b10 : 2'b00});
    end
    idle(12);

    // 8: randomized stimulus against the reference model
    model_on = 1'b1;
    for (int ph = 0; ph < 6; ph++) begin
      int lim;
      lim = $urandom_range(3, 12);
      for (int i = 0; i < 100; i++) begin
        logic [1:0] r;
        logic [3:0] e;
        r = btn_raw;
        for (int c = 0; c < 2; c++)
          if ($urandom_range(0, lim) == 0) r[c] = ~r[c];
        cyc(r);
        if (exp_q.size() == 0) begin
          check("rand_q_empty", 4'h1, 4'h0);
        end else begin
          e = exp_q.pop_front();
          check("rand", {btn_pulse, btn_level}, e);
        end
      end
    end
    model_on = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
